// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//
// Architectural register file sitting between write-back select and decode.
// Sinks the write-back result, serves two combinational decode read ports,
// and tracks a pending bit per register so decode can stall on a load-use
// hazard until that load's write-back arrives.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> write-through bypass: a register written this cycle is read
//                as WriteData and a pending register being written this cycle
//                does not stall.
//   undefined -> reads return the pre-edge contents; a pending register keeps
//                stalling until the cycle after its write-back.
//
// Parameters
//   NREG  number of registers (register 0 reads as zero, never pending)
//   DW    data width
//   AW    register address width, equal to clog2(NREG)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   RegWrite     write-back enable
//   WriteReg     write-back destination
//   WriteData    write-back data
//   ReadReg1/2   decode source addresses
//   ReadEn1/2    source actually used by the decode instruction
//   ReadData1/2  combinational read data
//   LoadIssue    a load leaves decode this cycle (ignored while stalled)
//   LoadDest     destination of that load
//   Stall        combinational load-use hazard indication
//   PendingMask  registered pending bits
// ---------------------------------------------------------------------------
module reg_file_wb #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite,
    input  logic [AW-1:0]   WriteReg,
    input  logic [DW-1:0]   WriteData,
    input  logic [AW-1:0]   ReadReg1,
    input  logic [AW-1:0]   ReadReg2,
    input  logic            ReadEn1,
    input  logic            ReadEn2,
    output logic [DW-1:0]   ReadData1,
    output logic [DW-1:0]   ReadData2,
    input  logic            LoadIssue,
    input  logic [AW-1:0]   LoadDest,
    output logic            Stall,
    output logic [NREG-1:0] PendingMask
);

    logic [DW-1:0]   rf [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;

    logic wr_ok;
    logic load_ok;
    logic resolved1;
    logic resolved2;
    logic hazard1;
    logic hazard2;

    assign wr_ok = RegWrite && (WriteReg != '0);

    // A stalled instruction has not left decode, so its LoadIssue is not real.
    assign load_ok = LoadIssue && !Stall && (LoadDest != '0);

    always_comb begin
        ReadData1 = (ReadReg1 == '0) ? '0 : rf[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : rf[ReadReg2];
`ifdef RF_BYPASS_EN
        resolved1 = wr_ok && (WriteReg == ReadReg1);
        resolved2 = wr_ok && (WriteReg == ReadReg2);
        if (resolved1) begin
            ReadData1 = WriteData;
        end
        if (resolved2) begin
            ReadData2 = WriteData;
        end
`else
        resolved1 = 1'b0;
        resolved2 = 1'b0;
`endif
    end

    assign hazard1 = ReadEn1 && (ReadReg1 != '0) && pend[ReadReg1] && !resolved1;
    assign hazard2 = ReadEn2 && (ReadReg2 != '0) && pend[ReadReg2] && !resolved2;
    assign Stall   = hazard1 || hazard2;

    // Clear first, then set: a newer load to the same register must remain
    // pending even though the older write-back completes in this cycle.
    always_comb begin
        pend_next = pend;
        if (wr_ok) begin
            pend_next[WriteReg] = 1'b0;
        end
        if (load_ok) begin
            pend_next[LoadDest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wr_ok) begin
                rf[WriteReg] <= WriteData;
            end
            pend <= pend_next;
        end
    end

    assign PendingMask = pend;

endmodule
